// File: rtl/startracker_pkg.sv
// Shared histogram defaults and state type, also consumed by the downstream
// derivative stage.
package startracker_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int BIN_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_CLEAR   = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_READOUT = 2'd3
  } hist_state_t;

endpackage

// File: rtl/hist_ram.sv
// Bin storage: simple dual-port RAM, one write port, one synchronous read port
// with 1-cycle latency. A read colliding with a write returns the old contents.
module hist_ram #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pixel_histogram.sv
// Frame intensity histogram: clear pass, saturating RMW accumulation with
// forwarding, then an in-order readout that zeroes each bin as it leaves.
module pixel_histogram
  import startracker_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int BIN_W = BIN_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_pix_valid,
  input  logic [PIX_W-1:0] i_pix_data,
  input  logic             i_pix_last,
  output logic             o_pix_ready,
  output logic             o_bin_valid,
  output logic [PIX_W-1:0] o_bin_idx,
  output logic [BIN_W-1:0] o_bin_count,
  output logic             o_bin_last,
  input  logic             i_bin_ready,
  output logic             o_overflow
);

  localparam logic [PIX_W-1:0] IDX_MAX = '1;
  localparam logic [BIN_W-1:0] CNT_MAX = '1;

  hist_state_t state, state_next;

  logic [PIX_W-1:0] clr_idx;
  logic             drain_cnt;
  logic             ovf_flag;

  logic             s2_valid;
  logic [PIX_W-1:0] s2_idx;
  logic             fwd_valid;
  logic [PIX_W-1:0] fwd_idx;
  logic [BIN_W-1:0] fwd_count;
  logic [BIN_W-1:0] base, inc;
  logic             sat;

  logic [PIX_W-1:0] rd_idx;
  logic             rd_done;
  logic             a_valid;
  logic [PIX_W-1:0] a_idx;
  logic             rd_issue;
  logic             b_load;

  logic             pix_fire, bin_fire;
  logic             ram_we, ram_re;
  logic [PIX_W-1:0] ram_waddr, ram_raddr;
  logic [BIN_W-1:0] ram_wdata, ram_rdata;

  assign o_pix_ready = (state == ST_ACCUM);
  assign pix_fire    = (state == ST_ACCUM) && i_pix_valid;
  assign bin_fire    = (state == ST_READOUT) && o_bin_valid && i_bin_ready;

  // The RAM read for the stage-2 pixel missed the write committed on the same
  // edge, so that last write is forwarded when it targets the same bin.
  assign base = (fwd_valid && (fwd_idx == s2_idx)) ? fwd_count : ram_rdata;
  assign sat  = (base == CNT_MAX);
  assign inc  = sat ? base : base + 1'b1;

  assign b_load   = a_valid && (!o_bin_valid || bin_fire);
  assign rd_issue = (state == ST_READOUT) && !rd_done && (!a_valid || b_load);

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    if (s2_valid) begin
      ram_we    = 1'b1;
      ram_waddr = s2_idx;
      ram_wdata = inc;
    end else if (state == ST_CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_idx;
    end else if (bin_fire) begin
      ram_we    = 1'b1;
      ram_waddr = o_bin_idx;
    end
    ram_re    = pix_fire || rd_issue;
    ram_raddr = (state == ST_READOUT) ? rd_idx : i_pix_data;
  end

  hist_ram #(.AW(PIX_W), .DW(BIN_W)) u_ram (
    .clk   (i_clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_CLEAR;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_CLEAR:   if (clr_idx == IDX_MAX) state_next = ST_ACCUM;
      ST_ACCUM:   if (pix_fire && i_pix_last) state_next = ST_DRAIN;
      ST_DRAIN:   if (drain_cnt) state_next = ST_READOUT;
      ST_READOUT: if (bin_fire && o_bin_last) state_next = ST_ACCUM;
      default:    state_next = ST_CLEAR;
    endcase
  end

  // DRAIN spans two cycles so the last pixel's write has landed before readout.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      clr_idx    <= '0;
      drain_cnt  <= 1'b0;
      s2_valid   <= 1'b0;
      s2_idx     <= '0;
      fwd_valid  <= 1'b0;
      fwd_idx    <= '0;
      fwd_count  <= '0;
      ovf_flag   <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      if (state == ST_CLEAR) clr_idx <= clr_idx + 1'b1;
      drain_cnt <= (state == ST_DRAIN) && !drain_cnt;
      s2_valid  <= pix_fire;
      s2_idx    <= i_pix_data;
      fwd_valid <= s2_valid;
      fwd_idx   <= s2_idx;
      fwd_count <= inc;
      if ((state == ST_DRAIN) && drain_cnt) begin
        o_overflow <= ovf_flag;
        ovf_flag   <= 1'b0;
      end else if (s2_valid && sat) begin
        ovf_flag <= 1'b1;
      end
    end
  end

  // Readout is a RAM-read stage feeding a holding output stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_idx      <= '0;
      rd_done     <= 1'b0;
      a_valid     <= 1'b0;
      a_idx       <= '0;
      o_bin_valid <= 1'b0;
      o_bin_idx   <= '0;
      o_bin_count <= '0;
      o_bin_last  <= 1'b0;
    end else if (state != ST_READOUT) begin
      rd_idx      <= '0;
      rd_done     <= 1'b0;
      a_valid     <= 1'b0;
      o_bin_valid <= 1'b0;
      o_bin_last  <= 1'b0;
    end else begin
      if (rd_issue) begin
        rd_idx  <= rd_idx + 1'b1;
        rd_done <= (rd_idx == IDX_MAX);
        a_idx   <= rd_idx;
        a_valid <= 1'b1;
      end else if (b_load) begin
        a_valid <= 1'b0;
      end
      if (b_load) begin
        o_bin_valid <= 1'b1;
        o_bin_idx   <= a_idx;
        o_bin_count <= ram_rdata;
        o_bin_last  <= (a_idx == IDX_MAX);
      end else if (bin_fire) begin
        o_bin_valid <= 1'b0;
        o_bin_last  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/pixel_histogram.md
PIXEL_HISTOGRAM -- requirements
Module: pixel_histogram

Interface
REQ-001 The module SHALL have parameter PIX_W, default 8, meaning pixel intensity width; the bin count is 2**PIX_W.
REQ-002 The module SHALL have parameter BIN_W, default 16, meaning the width of each bin counter.
REQ-003 The module SHALL have port i_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The module SHALL have port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have port i_pix_valid, input, 1 bit: pixel sample present.
REQ-006 The module SHALL have port i_pix_data, input, PIX_W bits: pixel intensity, used as the bin index.
REQ-007 The module SHALL have port i_pix_last, input, 1 bit: qualifies the final pixel of the frame.
REQ-008 The module SHALL have port o_pix_ready, output, 1 bit: the pixel is accepted when i_pix_valid and o_pix_ready are both 1.
REQ-009 The module SHALL have port o_bin_valid, output, 1 bit: a histogram bin is presented.
REQ-010 The module SHALL have port o_bin_idx, output, PIX_W bits: index of the presented bin.
REQ-011 The module SHALL have port o_bin_count, output, BIN_W bits: count of the presented bin.
REQ-012 The module SHALL have port o_bin_last, output, 1 bit: marks the presented bin as index 2**PIX_W-1.
REQ-013 The module SHALL have port i_bin_ready, input, 1 bit: the bin is accepted when o_bin_valid and i_bin_ready are both 1.
REQ-014 The module SHALL have port o_overflow, output, 1 bit: at least one bin saturated in the frame being read out.

Function
REQ-015 The module SHALL implement the states CLEAR, ACCUM, DRAIN and READOUT.
REQ-016 In CLEAR, the module SHALL write 0 to bins 0..2**PIX_W-1, one bin per cycle, then enter ACCUM; o_pix_ready and o_bin_valid SHALL be 0 in CLEAR.
REQ-017 In ACCUM, o_pix_ready SHALL be 1, and each accepted pixel SHALL increment bin[i_pix_data] by 1 through a two-stage read-modify-write pipeline (stage 1 reads, stage 2 writes).
REQ-018 A pixel hitting the same bin as the pixel in stage 2 SHALL use the forwarded stage-2 result, so that back-to-back identical pixels are all counted.
REQ-019 Each bin SHALL saturate at 2**BIN_W-1 with no wrap; any saturated increment SHALL set the internal overflow flag.
REQ-020 An accepted pixel with i_pix_last=1 SHALL be counted and SHALL move the state to DRAIN; o_pix_ready SHALL be 0 from the next cycle.
REQ-021 DRAIN SHALL last exactly until the RMW pipeline is empty (2 cycles) and then enter READOUT.
REQ-022 On entry to READOUT, o_overflow SHALL be updated from the internal flag, and the internal flag SHALL be cleared.
REQ-023 In READOUT, bins SHALL be presented in ascending order starting at index 0; the first o_bin_valid SHALL assert no later than 2 cycles after entry.
REQ-024 While o_bin_valid=1 and i_bin_ready=0, o_bin_idx, o_bin_count and o_bin_last SHALL hold stable.
REQ-025 Each accepted bin SHALL be written to 0 in the same cycle it is accepted, so that the next frame starts from cleared bins without a CLEAR pass.
REQ-026 Sustained throughput SHALL be one bin per cycle while i_bin_ready=1.
REQ-027 Acceptance of the bin with o_bin_last=1 SHALL return the state to ACCUM.
REQ-028 i_pix_valid SHALL be ignored outside ACCUM, and i_bin_ready SHALL be ignored outside READOUT.

Reset
REQ-029 Asserting i_rst_n low SHALL, asynchronously, set state to CLEAR, the bin-index counter to 0, and the RMW pipeline to empty.
REQ-030 Asserting i_rst_n low SHALL, asynchronously, set o_pix_ready=0, o_bin_valid=0, o_bin_idx=0, o_bin_count=0, o_bin_last=0, o_overflow=0 and the internal overflow flag to 0.
REQ-031 Reset asserted mid-frame or mid-readout SHALL discard all partial counts; the full CLEAR pass SHALL run after release.
REQ-032 Bin memory contents SHALL NOT be reset directly.

Structure
REQ-033 The defaults for PIX_W and BIN_W and the state enum type SHALL live in a shared package, startracker_pkg, also used by the downstream derivative stage.
REQ-034 Bin storage SHALL be a single sub-module, hist_ram: a 2**PIX_W x BIN_W simple dual-port RAM with synchronous read and 1-cycle read latency.
REQ-035 Counting, forwarding, saturation and FSM logic SHALL reside in pixel_histogram.

Verification
REQ-036 Reset release -> o_pix_ready stays 0 for 256 cycles (CLEAR), then rises to 1.
REQ-037 Pixels 5,5,5,7 on consecutive cycles, last on the 7 -> readout bin5=3, bin7=1, all other bins 0, o_bin_last only on idx 255.
REQ-038 65537 pixels of value 200 -> bin200=65535 and o_overflow=1; the following frame without saturation -> o_overflow=0.
REQ-039 Readout with i_bin_ready toggling 1,0,0,1 -> outputs stable while ready=0, no bin skipped or duplicated, 256 transfers total.
REQ-040 Two frames back-to-back: frame 1 has 10 pixels of value 3, frame 2 has 4 pixels of value 3 -> frame-2 readout gives bin3=4.
REQ-041 Reset pulsed during READOUT at idx 100 -> o_bin_valid drops immediately, a CLEAR pass runs, and the next frame's counts are correct.
